mod_reduce_seq: RTL and testbench



---
 rtl/mod_reduce_seq.sv | 91 +++++++++
 tb/tb_mod_reduce_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// Sequential X mod M reducer. X is consumed MSB-first, C bits per clock,
// using the Horner step acc = (acc*2^C + chunk) mod M. The result is held until handshaked.
module mod_reduce_seq #(
    parameter int W = 200,
    parameter int M = 461,
    parameter int C = 6,
    localparam int MW = $clog2(M),
    localparam int N  = (W + C - 1) / C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] z_out,
    output logic          busy
);

    localparam int SW = N * C;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = MW + C;
    localparam logic [TW-1:0] MT   = TW'(M);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (M < 2 || C < 1) begin : g_bad_params
            $error("mod_reduce_seq: M must be >= 2 and C must be >= 1");
        end
    endgenerate

    logic [1:0]    state;
    logic [SW-1:0] shreg;
    logic [MW-1:0] acc;
    logic [MW-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] t;
    logic [TW-1:0] t_mod;

    // t < M*2^C because acc < M, so a constant-divisor remainder yields a value in [0, M).
    always_comb begin
        t       = {acc, shreg[SW-1 -: C]};
        t_mod   = t % MT;
        acc_nxt = t_mod[MW-1:0];
    end

    assign in_ready  = (state == S_IDLE) && !rst;
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            z_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Zero-extension at the MSB pads the top chunk when W is not a multiple of C.
                        shreg <= SW'(x_in);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc   <= acc_nxt;
                    shreg <= shreg << C;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        z_out <= acc_nxt;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Randomized bench for mod_reduce_seq: a cycle-level behavioural model computes X mod M
// directly, and a compare process checks every cycle. Two small parameter sets are also covered.
module tb_mod_reduce_seq;

    localparam int W  = 200;
    localparam int M  = 461;
    localparam int MW = 9;
    localparam int N  = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  x_in      = '0;
    logic          in_ready, out_valid, busy;
    logic [MW-1:0] z_out;

    mod_reduce_seq #(.W(W), .M(M), .C(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out), .busy(busy)
    );

    logic        s1_iv = 1'b0, s1_or = 1'b0;
    logic [11:0] s1_x  = '0;
    logic        s1_ir, s1_ov, s1_busy;
    logic [3:0]  s1_z;

    mod_reduce_seq #(.W(12), .M(13), .C(6)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(s1_iv), .in_ready(s1_ir), .x_in(s1_x),
        .out_valid(s1_ov), .out_ready(s1_or), .z_out(s1_z), .busy(s1_busy)
    );

    logic        s2_iv = 1'b0, s2_or = 1'b0;
    logic [9:0]  s2_x  = '0;
    logic        s2_ir, s2_ov, s2_busy;
    logic [8:0]  s2_z;

    mod_reduce_seq #(.W(10), .M(461), .C(4)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(s2_iv), .in_ready(s2_ir), .x_in(s2_x),
        .out_valid(s2_ov), .out_ready(s2_or), .z_out(s2_z), .busy(s2_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int gold(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x % W'(M);
        return int'(r[MW-1:0]);
    endfunction

    function automatic logic [W-1:0] rnd_x();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom();
        return r[W-1:0];
    endfunction

    // Behavioural model: an accepted operand yields X mod M exactly N edges later,
    // held until out_ready; reset discards anything in flight.
    bit m_idle  = 1'b1;
    bit m_valid = 1'b0;
    int m_cnt   = 0;
    int m_z     = 0;
    int m_pend  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1'b1; m_valid = 1'b0; m_cnt = 0; m_z = 0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 1'b0; m_idle = 1'b1; end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_valid = 1'b1; m_z = m_pend; end
        end else if (m_idle && in_valid) begin
            m_idle = 1'b0; m_cnt = N; m_pend = gold(x_in);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        chk("cyc_in_ready", in_ready, m_idle && !rst);
        chk("cyc_out_valid", out_valid, m_valid);
        chk("cyc_busy", busy, m_cnt > 0);
        chk("cyc_z_out", z_out, m_z);
    end

    task automatic do_op(input logic [W-1:0] x, input int lit, input int hold);
        int k;
        @(negedge clk); in_valid = 1'b1; x_in = x;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        chk("op_accept", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; x_in = rnd_x();
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        chk("op_latency", k, N);
        chk("op_z_gold", z_out, gold(x));
        chk("op_z_range", z_out < M, 1);
        if (lit >= 0) chk("op_z_literal", z_out, lit);
        repeat (hold) begin
            @(negedge clk);
            chk("op_hold_valid", out_valid, 1);
            chk("op_hold_z", z_out, gold(x));
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic s1_op(input logic [11:0] x, input int lit);
        int k;
        @(negedge clk); s1_iv = 1'b1; s1_x = x;
        k = 0;
        while (!s1_ir && k < 20) begin @(negedge clk); k++; end
        chk("s1_accept", s1_ir, 1);
        @(negedge clk); s1_iv = 1'b0; s1_x = 12'hABC;
        k = 0;
        while (!s1_ov && k < 20) begin @(negedge clk); k++; end
        chk("s1_latency", k, 2);
        chk("s1_z", s1_z, lit);
        s1_or = 1'b1; @(negedge clk); s1_or = 1'b0;
    endtask

    task automatic s2_op(input logic [9:0] x, input int lit);
        int k;
        @(negedge clk); s2_iv = 1'b1; s2_x = x;
        k = 0;
        while (!s2_ir && k < 20) begin @(negedge clk); k++; end
        chk("s2_accept", s2_ir, 1);
        @(negedge clk); s2_iv = 1'b0; s2_x = 10'h155;
        k = 0;
        while (!s2_ov && k < 20) begin @(negedge clk); k++; end
        chk("s2_latency", k, 3);
        chk("s2_z", s2_z, lit);
        s2_or = 1'b1; @(negedge clk); s2_or = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_z_out", z_out, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 chk("rst_release_in_ready", in_ready, 1);

        do_op(200'd0, 0, 0);
        do_op(200'd461, 0, 1);
        do_op(200'd460, 460, 0);
        do_op(200'd1000, 78, 2);
        do_op(200'd4096, 408, 0);
        do_op(200'd262144, 296, 0);
        do_op('1, -1, 0);

        // Back-pressure with in_valid held high and a new operand waiting.
        @(negedge clk); in_valid = 1'b1; x_in = 200'd4096;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk); x_in = 200'd262144;
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        chk("bp_latency", k, N);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_z", z_out, 408);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        chk("bp_ready_after_hs", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        chk("bp_busy_next", busy, 1);
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        chk("bp_latency2", k, N);
        chk("bp_z2", z_out, 296);
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

        // Reset in the middle of an operation.
        @(negedge clk); in_valid = 1'b1; x_in = 200'd12345;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk); in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_z", z_out, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 chk("mid_release_in_ready", in_ready, 1);
        repeat (N + 4) begin
            @(negedge clk);
            chk("mid_no_result", out_valid, 0);
        end
        do_op(200'd1000, 78, 0);

        for (int i = 0; i < 1000; i++)
            do_op(rnd_x() >> $urandom_range(0, W - 1), -1, $urandom_range(0, 2));

        s1_op(12'd4095, 0);
        s1_op(12'd100, 9);
        s2_op(10'd1023, 101);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
